// File: rtl/sdram_host_queue_if.sv
// sdram_host_queue_if: host request/response port and SDRAM controller host-port bundle
interface sdram_host_queue_if #(
  parameter int HADDR_WIDTH = 24,
  parameter int DEPTH = 4
);
  logic req_valid, req_ready, req_we;
  logic [HADDR_WIDTH-1:0] req_addr;
  logic [15:0] req_wdata;
  logic rsp_valid;
  logic [15:0] rsp_data;
  logic [HADDR_WIDTH-1:0] ctrl_wr_addr, ctrl_rd_addr;
  logic [15:0] ctrl_wr_data, ctrl_rd_data;
  logic ctrl_wr_enable, ctrl_rd_enable, ctrl_rd_ready, ctrl_busy;
  logic [$clog2(DEPTH):0] pending;
  logic err_timeout;
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, ctrl_rd_data, ctrl_rd_ready, ctrl_busy,
    output req_ready, rsp_valid, rsp_data, ctrl_wr_addr, ctrl_wr_data, ctrl_wr_enable,
    ctrl_rd_addr, ctrl_rd_enable, pending, err_timeout
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, ctrl_rd_data, ctrl_rd_ready, ctrl_busy,
    input req_ready, rsp_valid, rsp_data, ctrl_wr_addr, ctrl_wr_data, ctrl_wr_enable,
    ctrl_rd_addr, ctrl_rd_enable, pending, err_timeout
  );
endinterface

// File: rtl/sdram_host_queue.sv
// sdram_host_queue: request FIFO that issues one op at a time to the SDRAM controller host port
module sdram_host_queue #(
  parameter int HADDR_WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int ISSUE_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  sdram_host_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  localparam int EW = HADDR_WIDTH + 17;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(ISSUE_TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(ISSUE_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nx;
  logic [TW-1:0] tmo_cnt;
  logic push, pop, load, rd_pend, rd_hit;
  assign push = bus.req_valid & bus.req_ready;
  assign head = mem[rd_ptr];
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_hit = bus.ctrl_rd_ready & rd_pend;
  assign bus.pending = count;
  always_comb begin
    state_nx = state;
    load = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: if (|count) begin
        state_nx = ISSUE;
        load = 1'b1;
      end
      ISSUE: if (bus.ctrl_busy) begin
        state_nx = WAIT_DONE;
        pop = 1'b1;
      end
      WAIT_DONE: state_nx = (!bus.ctrl_busy && !rd_pend) ? IDLE : WAIT_DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.req_we, bus.req_addr, bus.req_wdata};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tmo_cnt <= '0;
      rd_pend <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.ctrl_wr_addr <= '0;
      bus.ctrl_wr_data <= '0;
      bus.ctrl_wr_enable <= 1'b0;
      bus.ctrl_rd_addr <= '0;
      bus.ctrl_rd_enable <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      bus.req_ready <= count_nx != FULL;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (load) begin
        if (head[EW-1]) begin
          bus.ctrl_wr_addr <= head[EW-2:16];
          bus.ctrl_wr_data <= head[15:0];
        end else bus.ctrl_rd_addr <= head[EW-2:16];
        bus.ctrl_wr_enable <= head[EW-1];
        bus.ctrl_rd_enable <= !head[EW-1];
        rd_pend <= !head[EW-1];
        tmo_cnt <= '0;
      end
      if (pop) begin
        bus.ctrl_wr_enable <= 1'b0;
        bus.ctrl_rd_enable <= 1'b0;
      end
      // timeout only flags a stuck controller; the enable keeps waiting
      if (state == ISSUE && !bus.ctrl_busy) begin
        if (tmo_cnt != TMAX) tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TLAST) bus.err_timeout <= 1'b1;
      end
      bus.rsp_valid <= rd_hit;
      if (rd_hit) begin
        bus.rsp_data <= bus.ctrl_rd_data;
        rd_pend <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sdram_host_queue.sv
// tb_sdram_host_queue: directed stimulus with issue/response scoreboards and a controller model
module tb_sdram_host_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sdram_host_queue_if bus ();
  sdram_host_queue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0;
  logic [40:0] exp_issue [$];
  logic [15:0] exp_rsp [$];
  logic [15:0] ref_mem [logic [23:0]];
  logic [15:0] cmem [logic [23:0]];
  logic mute = 1'b0, stall = 1'b0, spur = 1'b0;
  int lag = 2, blen = 3;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d);
    int n = 0;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", bus.req_ready, 1);
    if (bus.req_ready) begin
      exp_issue.push_back({we, a, d});
      if (we) ref_mem[a] = d;
      else exp_rsp.push_back(ref_mem.exists(a) ? ref_mem[a] : 16'h0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || bus.ctrl_wr_enable ||
            bus.ctrl_rd_enable || bus.pending != 0 || bus.ctrl_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
    repeat (4) @(negedge clk);
  endtask
  // controller model: busy rises lag cycles after an enable, stays high blen cycles
  initial begin
    int phase = 0, cnt = 0;
    logic op_we = 1'b0;
    logic [23:0] op_addr = '0;
    logic [15:0] op_data = '0;
    bus.ctrl_busy = 1'b0;
    bus.ctrl_rd_ready = 1'b0;
    bus.ctrl_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ctrl_rd_ready = 1'b0;
      if (!rst_n) begin
        phase = 0;
        bus.ctrl_busy = 1'b0;
      end else if (phase == 0) begin
        bus.ctrl_busy = 1'b0;
        if (!mute && (bus.ctrl_wr_enable || bus.ctrl_rd_enable)) begin
          phase = 1;
          cnt = lag;
          op_we = bus.ctrl_wr_enable;
          op_addr = op_we ? bus.ctrl_wr_addr : bus.ctrl_rd_addr;
          op_data = bus.ctrl_wr_data;
        end
      end else if (phase == 1) begin
        if (cnt > 1) cnt--;
        else begin
          bus.ctrl_busy = 1'b1;
          phase = 2;
          cnt = blen;
          if (op_we) cmem[op_addr] = op_data;
        end
      end else if (!stall) begin
        if (cnt > 1) cnt--;
        else begin
          bus.ctrl_busy = 1'b0;
          phase = 0;
          if (!op_we) begin
            bus.ctrl_rd_ready = 1'b1;
            bus.ctrl_rd_data = cmem.exists(op_addr) ? cmem[op_addr] : 16'h0;
          end
        end
      end
      if (spur) begin
        bus.ctrl_rd_ready = 1'b1;
        bus.ctrl_rd_data = 16'h1234;
        spur = 1'b0;
      end
    end
  end
  // monitor: checks every issued op and every response against the scoreboards
  initial begin
    logic pw = 1'b0, pr = 1'b0, pb = 1'b0;
    logic [40:0] e;
    logic [24:0] op;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ctrl_wr_enable || bus.ctrl_rd_enable)
          chk("one_enable", bus.ctrl_wr_enable & bus.ctrl_rd_enable, 0);
        if ((bus.ctrl_wr_enable && !pw) || (bus.ctrl_rd_enable && !pr)) begin
          chk("busy_low_at_issue", bus.ctrl_busy, 0);
          if (exp_issue.size() == 0) chk("issue_expected", exp_issue.size(), 1);
          else begin
            e = exp_issue.pop_front();
            op = bus.ctrl_wr_enable ? {1'b1, bus.ctrl_wr_addr} : {1'b0, bus.ctrl_rd_addr};
            chk("issue_op", op, e[40:16]);
            if (bus.ctrl_wr_enable) chk("issue_wdata", bus.ctrl_wr_data, e[15:0]);
          end
        end
        if ((pw && !bus.ctrl_wr_enable) || (pr && !bus.ctrl_rd_enable))
          chk("drop_after_busy", pb, 1);
        if (bus.rsp_valid) begin
          if (exp_rsp.size() == 0) chk("rsp_expected", bus.rsp_valid, 0);
          else chk("rsp_data", bus.rsp_data, exp_rsp.pop_front());
        end
      end
      pw = bus.ctrl_wr_enable;
      pr = bus.ctrl_rd_enable;
      pb = bus.ctrl_busy;
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_pending", bus.pending, 0);
    chk("rst_enables", {bus.ctrl_wr_enable, bus.ctrl_rd_enable}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_data}, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push(1'b1, 24'h012345, 16'hBEEF);
    wait_idle();
    chk("t2_wr_addr", bus.ctrl_wr_addr, 24'h012345);
    chk("t2_wr_data", bus.ctrl_wr_data, 16'hBEEF);
    chk("t2_wr_enable_low", bus.ctrl_wr_enable, 0);
    push(1'b1, 24'h000010, 16'hA5A5);
    push(1'b0, 24'h000010, 16'h0000);
    wait_idle();
    chk("t3_rsp_data_held", bus.rsp_data, 16'hA5A5);
    push(1'b1, 24'h000020, 16'h5555);
    n = 0;
    while (!bus.ctrl_wr_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_wr_enable_seen", bus.ctrl_wr_enable, 1);
    spur = 1'b1;
    wait_idle();
    chk("t6_rsp_data_unchanged", bus.rsp_data, 16'hA5A5);
    stall = 1'b1;
    push(1'b1, 24'h000100, 16'h0F0F);
    repeat (10) @(negedge clk);
    chk("t4_first_taken", bus.pending, 0);
    push(1'b1, 24'h000200, 16'h1111);
    push(1'b0, 24'h000200, 16'h0000);
    push(1'b1, 24'h000201, 16'h2222);
    push(1'b0, 24'h000201, 16'h0000);
    chk("t4_full_pending", bus.pending, 4);
    chk("t4_full_not_ready", bus.req_ready, 0);
    bus.req_we = 1'b1;
    bus.req_addr = 24'h000300;
    bus.req_wdata = 16'h3333;
    bus.req_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_fifth_refused", bus.req_ready, 0);
    chk("t4_pending_still_4", bus.pending, 4);
    bus.req_valid = 1'b0;
    stall = 1'b0;
    wait_idle();
    mute = 1'b1;
    push(1'b0, 24'h000010, 16'h0000);
    repeat (200) @(negedge clk);
    chk("t5_no_err_early", bus.err_timeout, 0);
    chk("t5_rd_held_early", bus.ctrl_rd_enable, 1);
    repeat (100) @(negedge clk);
    chk("t5_err_set", bus.err_timeout, 1);
    chk("t5_rd_still_held", bus.ctrl_rd_enable, 1);
    mute = 1'b0;
    wait_idle();
    chk("t5_err_sticky", bus.err_timeout, 1);
    mute = 1'b1;
    push(1'b0, 24'h000201, 16'h0000);
    repeat (5) @(negedge clk);
    chk("t1_rd_enable_before", bus.ctrl_rd_enable, 1);
    void'(exp_rsp.pop_back());
    #2 rst_n = 1'b0;
    #1;
    chk("t1_enables_async", {bus.ctrl_wr_enable, bus.ctrl_rd_enable}, 0);
    chk("t1_pending", bus.pending, 0);
    chk("t1_req_ready", bus.req_ready, 1);
    chk("t1_err_cleared", bus.err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mute = 1'b0;
    repeat (20) @(negedge clk);
    chk("t1_idle_after", {bus.ctrl_wr_enable, bus.ctrl_rd_enable, bus.rsp_valid}, 0);
    chk("t1_pending_after", bus.pending, 0);
    chk("scoreboard_empty", exp_issue.size() + exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
